// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared state encoding and index constants for reg_dump
package reg_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

    localparam int DEF_ADDR_W = 5;

    // Index of the final entry of a scan over 2^addr_w registers.
    function automatic int last_index(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    localparam int DONE_IDX = last_index(DEF_ADDR_W);

endpackage

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - walks a register file read port and streams every entry out with its index
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(last_index(ADDR_W));

    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              accept;

    assign accept = (state == ST_HOLD) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over everything, including an acceptance in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !abort) state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = abort ? ST_IDLE : ST_HOLD;
            ST_HOLD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (accept) begin
                    state_nxt = (cnt == LAST_IDX) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else if (!abort) begin
            case (state)
                ST_IDLE: if (start) cnt <= '0;
                ST_ADDR: begin
                    out_data <= rd_data;
                    out_idx  <= cnt;
                end
                ST_HOLD: if (accept && cnt != LAST_IDX) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_addr   = cnt;
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - self-checking bench for reg_dump
module tb_reg_dump;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          out_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [N];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    assign rd_data = mem[rd_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_dump #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        bit       start;
        bit       abort;
        bit       ready;
        bit       busy;
        bit       valid;
        bit       done;
        int       idx;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high; 1: random ready; 2: stall 10 cycles on idx 7.
    // kill_idx >= 0 aborts (or resets when kill_rst) while that index is presented.
    task automatic scan(input int mode, input int poke_idx, input int kill_idx, input bit kill_rst);
        int nxt = 0;
        int stall = 0;
        int t0;
        bit seen_valid = 0;
        bit fin = 0;
        start = 1'b1;
        abort = 1'b0;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        t0 = cyc;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (done) begin
                if (mode == 0) chk("done_cycle", cyc - t0, 64);
                chk("words_before_done", nxt, N);
                out_ready = 1'b0;
                step();
                chk("idle_after_done", busy, 0);
                chk("done_single_cycle", done, 0);
                fin = 1;
            end else begin
                if (out_valid && !seen_valid) begin
                    seen_valid = 1;
                    if (mode == 0) chk("first_valid_cycle", cyc - t0, 1);
                end
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mode == 2 && out_valid && out_idx == 7 && stall < 10) begin
                    out_ready = 1'b0;
                    chk("stall_data", out_data, mem[7]);
                    chk("stall_idx", out_idx, 7);
                    stall++;
                end
                start = out_valid && (int'(out_idx) == poke_idx);
                if (out_valid && int'(out_idx) == kill_idx) begin
                    out_ready = 1'b1;
                    if (kill_rst) rst = 1'b1;
                    else abort = 1'b1;
                    step();
                    rst = 1'b0;
                    abort = 1'b0;
                    start = 1'b0;
                    chk("kill_busy", busy, 0);
                    chk("kill_valid", out_valid, 0);
                    chk("kill_done", done, 0);
                    chk("accepted_before_kill", nxt, kill_idx);
                    if (kill_rst) begin
                        chk("rst_rd_addr", rd_addr, 0);
                        chk("rst_out_data", out_data, 0);
                        chk("rst_out_idx", out_idx, 0);
                    end
                    step();
                    chk("no_done_after_kill", done, 0);
                    chk("idle_after_kill", busy, 0);
                    fin = 1;
                end else begin
                    if (out_valid && out_ready) begin
                        chk("word_idx", out_idx, nxt);
                        chk("word_data", out_data, (nxt < N) ? mem[nxt] : 'x);
                        nxt++;
                    end
                    step();
                end
            end
        end
        start = 1'b0;
        if (!fin) chk("scan_timeout", 0, 1);
        if (mode == 2) chk("stall_cycles", stall, 10);
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 0, 0, 1, 0, 0, 0};
        vecs[4] = '{0, 0, 0, 1, 1, 0, 0};
        vecs[5] = '{1, 0, 0, 1, 1, 0, 0};
        vecs[6] = '{0, 0, 1, 1, 0, 0, 0};
        vecs[7] = '{0, 0, 0, 1, 1, 0, 1};
        vecs[8] = '{0, 1, 1, 0, 0, 0, 0};
        vecs[9] = '{0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < N; i++) mem[i] = DW'(i) * 32'h1111_1111;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_idx", out_idx, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            start = vecs[i].start;
            abort = vecs[i].abort;
            out_ready = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].valid);
            chk($sformatf("vec%0d_done", i), done, vecs[i].done);
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_idx", i), out_idx, vecs[i].idx);
                chk($sformatf("vec%0d_data", i), out_data, mem[vecs[i].idx]);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        step();

        chk("pattern_idx5", mem[5], 32'h5555_5555);
        scan(0, -1, -1, 0);
        scan(2, -1, -1, 0);
        scan(0, 3, -1, 0);
        scan(0, -1, 12, 0);
        scan(0, -1, 20, 1);
        scan(0, -1, -1, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) mem[i] = $urandom;
            scan(1, -1, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
